// File: rtl/clock_pkg.sv
// Shared types and constants for the 12-hour clock set controller and display driver.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  localparam logic [3:0] HOUR_MIN = 4'd1;
  localparam logic [3:0] HOUR_MAX = 4'd12;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  // set_mode encodings, also decoded by the display driver
  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_SET_HR  = 2'b01;
  localparam logic [1:0] MODE_SET_MIN = 2'b10;

  typedef struct packed {
    logic [3:0] hours;
    logic [5:0] minutes;
    logic       am_pm;
  } clk_time_t;

  localparam clk_time_t RESET_TIME = '{hours: HOUR_MAX, minutes: 6'd0, am_pm: 1'b0};

  // 11 -> 12 flips AM/PM; 12 -> 1 keeps it
  function automatic clk_time_t hour_inc(clk_time_t t);
    clk_time_t r;
    r = t;
    if (t.hours == HOUR_MAX - 4'd1) begin
      r.hours = HOUR_MAX;
      r.am_pm = ~t.am_pm;
    end else if (t.hours >= HOUR_MAX) begin
      r.hours = HOUR_MIN;
    end else begin
      r.hours = t.hours + 4'd1;
    end
    return r;
  endfunction

  // minutes wrap without carrying into hours
  function automatic logic [5:0] min_inc(logic [5:0] m);
    return (m >= MIN_MAX) ? 6'd0 : m + 6'd1;
  endfunction

  // COMMIT is shown as RUN: it lasts one cycle and the display is not blinking
  function automatic logic [1:0] mode_of(state_e s);
    case (s)
      ST_SET_HR:  return MODE_SET_HR;
      ST_SET_MIN: return MODE_SET_MIN;
      default:    return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button / core-side bundle of the clock set controller.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       cur_am_pm;
  logic       tick_1hz;
  logic       load;
  logic [3:0] load_hours;
  logic [5:0] load_minutes;
  logic       load_am_pm;
  logic [1:0] set_mode;
  logic       blink;

  modport master (
    output btn_mode, btn_inc, cur_hours, cur_minutes, cur_am_pm,
    input  tick_1hz, load, load_hours, load_minutes, load_am_pm, set_mode, blink
  );

  modport slave (
    input  btn_mode, btn_inc, cur_hours, cur_minutes, cur_am_pm,
    output tick_1hz, load, load_hours, load_minutes, load_am_pm, set_mode, blink
  );
endinterface

// File: rtl/clock_set_ctrl_prescaler.sv
// Free-running divider: one-cycle pulses at the end and at the middle of each second.
// CLK_HZ must be even and >= 4 so both pulses land on distinct counts.
module clk_prescaler #(
  parameter int CLK_HZ = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic sec_pulse,
  output logic half_pulse
);
  localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 2;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2 - 1);

  logic [CW-1:0] count;

  // count 0..CLK_HZ-1; clear restarts the second (used on commit)
  always_ff @(posedge clk) begin
    if (rst || clear || count == LAST) count <= '0;
    else                               count <= count + CW'(1);
  end

  assign sec_pulse  = (count == LAST);
  assign half_pulse = (count == HALF);
endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer for the 12-hour clock core: 1 Hz advance enable, two-button
// set FSM with a shadow time that is committed to the core by a single load strobe.
module clock_set_ctrl #(
  parameter int CLK_HZ    = 12_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic             clk,
  input  logic             rst,
  clock_set_ctrl_if.slave  bus
);
  import clock_pkg::*;

  localparam int TW = $clog2(TIMEOUT_S + 1);

  state_e    state, state_n;
  logic      mode_q, inc_q;
  logic      mode_p, inc_p;
  logic      sec_pulse, half_pulse, clr;
  logic      in_set, tmo_hit;
  logic      sec_q, load_q, blink_q;
  logic [TW-1:0] tmo;
  clk_time_t shadow;

  assign in_set = (state == ST_SET_HR) || (state == ST_SET_MIN);
  assign clr    = (state == ST_COMMIT);

  clk_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
    .clk       (clk),
    .rst       (rst),
    .clear     (clr),
    .sec_pulse (sec_pulse),
    .half_pulse(half_pulse)
  );

  // edge history starts high so a button held through reset is not a press
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b1;
      inc_q  <= 1'b1;
    end else begin
      mode_q <= bus.btn_mode;
      inc_q  <= bus.btn_inc;
    end
  end

  // mode wins over a simultaneous inc
  assign mode_p = bus.btn_mode & ~mode_q;
  assign inc_p  = bus.btn_inc & ~inc_q & ~mode_p;

  // inactivity timer: seconds seen in set modes since entry or last press
  always_ff @(posedge clk) begin
    if (rst || !in_set || mode_p || inc_p) tmo <= '0;
    else if (sec_pulse)                    tmo <= tmo + TW'(1);
  end

  assign tmo_hit = in_set && sec_pulse && !mode_p && !inc_p && (tmo == TW'(TIMEOUT_S - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_n;
  end

  // next-state: mode steps through the set modes, timeout abandons the edit
  always_comb begin
    state_n = state;
    case (state)
      ST_RUN:     if (mode_p) state_n = ST_SET_HR;
      ST_SET_HR:  if (mode_p) state_n = ST_SET_MIN;
                  else if (tmo_hit) state_n = ST_RUN;
      ST_SET_MIN: if (mode_p) state_n = ST_COMMIT;
                  else if (tmo_hit) state_n = ST_RUN;
      default:    state_n = ST_RUN;
    endcase
  end

  // shadow time: captured from the core on entry, edited by inc presses
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RESET_TIME;
    end else begin
      case (state)
        ST_RUN:     if (mode_p) shadow <= '{hours:   bus.cur_hours,
                                            minutes: bus.cur_minutes,
                                            am_pm:   bus.cur_am_pm};
        ST_SET_HR:  if (inc_p)  shadow <= hour_inc(shadow);
        ST_SET_MIN: if (inc_p)  shadow.minutes <= min_inc(shadow.minutes);
        default:    ;
      endcase
    end
  end

  // output registers; the second pulse is dropped on the commit cycle so the
  // first tick after a load is a full second after the prescaler restart
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q   <= 1'b0;
      load_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      sec_q   <= sec_pulse & ~clr;
      load_q  <= clr;
      blink_q <= in_set ? (blink_q ^ (sec_pulse | half_pulse)) : 1'b0;
    end
  end

  assign bus.tick_1hz     = sec_q & (state == ST_RUN);
  assign bus.load         = load_q;
  assign bus.load_hours   = shadow.hours;
  assign bus.load_minutes = shadow.minutes;
  assign bus.load_am_pm   = shadow.am_pm;
  assign bus.set_mode     = mode_of(state);
  assign bus.blink        = blink_q & in_set;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with CLK_HZ=10, TIMEOUT_S=3.
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.CLK_HZ(10), .TIMEOUT_S(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vecs   = 0;
  int errs   = 0;
  int n_tick = 0;
  int n_load = 0;

  // advance one clock, sample 1 time unit after the edge, tally strobes
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.tick_1hz === 1'b1) n_tick++;
    if (bus.load === 1'b1)     n_load++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one-cycle button pulse, then one idle cycle
  task automatic press(input logic m, input logic i);
    bus.btn_mode = m;
    bus.btn_inc  = i;
    step();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    step();
  endtask

  initial begin
    logic prev_blink;
    int   toggles;
    logic done;

    bus.btn_mode    = 1'b0;
    bus.btn_inc     = 1'b0;
    bus.cur_hours   = 4'd0;
    bus.cur_minutes = 6'd0;
    bus.cur_am_pm   = 1'b0;

    // ---- 1: reset values, then 1 Hz ticks at cycles 10, 20, 30
    rst = 1'b1;
    step();
    step();
    chk("rst_tick",  32'(bus.tick_1hz),     32'd0);
    chk("rst_load",  32'(bus.load),         32'd0);
    chk("rst_hours", 32'(bus.load_hours),   32'd12);
    chk("rst_min",   32'(bus.load_minutes), 32'd0);
    chk("rst_ampm",  32'(bus.load_am_pm),   32'd0);
    chk("rst_mode",  32'(bus.set_mode),     32'd0);
    chk("rst_blink", 32'(bus.blink),        32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("t1_tick", 32'(bus.tick_1hz), 32'(i % 10 == 0));
    end
    chk("t1_mode", 32'(bus.set_mode), 32'd0);

    // ---- 2: 11:58 AM -> 12:00 PM through both set modes, then commit
    bus.cur_hours   = 4'd11;
    bus.cur_minutes = 6'd58;
    bus.cur_am_pm   = 1'b0;
    n_tick = 0;
    n_load = 0;
    press(1'b1, 1'b0);
    chk("t2_mode_hr", 32'(bus.set_mode),     32'd1);
    chk("t2_cap_hr",  32'(bus.load_hours),   32'd11);
    chk("t2_cap_min", 32'(bus.load_minutes), 32'd58);
    chk("t2_cap_ap",  32'(bus.load_am_pm),   32'd0);
    press(1'b0, 1'b1);
    chk("t2_hr12",    32'(bus.load_hours),   32'd12);
    chk("t2_pm",      32'(bus.load_am_pm),   32'd1);
    press(1'b1, 1'b0);
    chk("t2_mode_min", 32'(bus.set_mode),    32'd2);
    press(1'b0, 1'b1);
    chk("t2_min59",   32'(bus.load_minutes), 32'd59);
    press(1'b0, 1'b1);
    chk("t2_min0",    32'(bus.load_minutes), 32'd0);
    chk("t2_hr_keep", 32'(bus.load_hours),   32'd12);
    chk("t2_ap_keep", 32'(bus.load_am_pm),   32'd1);
    chk("t2_no_tick", 32'(n_tick),           32'd0);
    chk("t2_no_load", 32'(n_load),           32'd0);
    press(1'b1, 1'b0);
    chk("t2_load",    32'(bus.load),         32'd1);
    chk("t2_ld_hr",   32'(bus.load_hours),   32'd12);
    chk("t2_ld_min",  32'(bus.load_minutes), 32'd0);
    chk("t2_ld_ap",   32'(bus.load_am_pm),   32'd1);
    chk("t2_ld_mode", 32'(bus.set_mode),     32'd0);
    chk("t2_ld_tick", 32'(n_tick),           32'd0);
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("t2_load_off", 32'(bus.load),     32'd0);
      chk("t2_tick",     32'(bus.tick_1hz), 32'(j == 10));
    end

    // ---- 3: 12 PM + inc -> 1 PM
    bus.cur_hours   = 4'd12;
    bus.cur_minutes = 6'd30;
    bus.cur_am_pm   = 1'b1;
    n_load = 0;
    press(1'b1, 1'b0);
    chk("t3_mode", 32'(bus.set_mode),   32'd1);
    chk("t3_cap",  32'(bus.load_hours), 32'd12);
    press(1'b0, 1'b1);
    chk("t3_hr1",  32'(bus.load_hours), 32'd1);
    chk("t3_pm",   32'(bus.load_am_pm), 32'd1);

    // ---- 4: idle in SET_HR: blink every half second, then timeout to RUN
    prev_blink = bus.blink;
    toggles    = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.blink !== prev_blink) toggles++;
      prev_blink = bus.blink;
    end
    chk("t4_blink_toggles", 32'(toggles),      32'd4);
    chk("t4_still_set",     32'(bus.set_mode), 32'd1);
    done = 1'b0;
    for (int k = 0; k < 15 && !done; k++) begin
      step();
      if (bus.set_mode === 2'b00) done = 1'b1;
    end
    chk("t4_timeout_run", 32'(done),      32'd1);
    chk("t4_no_load",     32'(n_load),    32'd0);
    chk("t4_blink_run",   32'(bus.blink), 32'd0);
    n_tick = 0;
    for (int k = 0; k < 11; k++) step();
    chk("t4_tick_resume", 32'(n_tick), 32'd1);

    // ---- 5: simultaneous mode+inc, then inc held high
    bus.cur_hours   = 4'd3;
    bus.cur_minutes = 6'd15;
    bus.cur_am_pm   = 1'b0;
    press(1'b1, 1'b0);
    chk("t5_mode_hr", 32'(bus.set_mode),   32'd1);
    chk("t5_cap_hr",  32'(bus.load_hours), 32'd3);
    press(1'b1, 1'b1);
    chk("t5_mode_win", 32'(bus.set_mode),  32'd2);
    chk("t5_hr_keep",  32'(bus.load_hours), 32'd3);
    bus.btn_inc = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("t5_held_inc", 32'(bus.load_minutes), 32'd16);
    chk("t5_mode_min", 32'(bus.set_mode),     32'd2);
    bus.btn_inc = 1'b0;

    // ---- 6: reset mid-edit with mode held across it
    bus.btn_mode = 1'b1;
    rst = 1'b1;
    n_load = 0;
    step();
    rst = 1'b0;
    chk("t6_mode",  32'(bus.set_mode),     32'd0);
    chk("t6_load",  32'(bus.load),         32'd0);
    chk("t6_hours", 32'(bus.load_hours),   32'd12);
    chk("t6_min",   32'(bus.load_minutes), 32'd0);
    chk("t6_blink", 32'(bus.blink),        32'd0);
    for (int k = 0; k < 5; k++) step();
    chk("t6_held_no_press", 32'(bus.set_mode), 32'd0);
    chk("t6_never_load",    32'(n_load),       32'd0);
    bus.btn_mode = 1'b0;
    step();
    press(1'b1, 1'b0);
    chk("t6_press_after", 32'(bus.set_mode), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
